// File: rtl/alu_op_sequencer.sv
// Request/response front end for the single-bit-shift ALU: latches one op,
// drives the ALU, iterates shifts shamt times and holds the result until accepted.
module alu_op_sequencer #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  input  logic [SHAMT_W-1:0] req_shamt,
  output logic [DATA_W-1:0]  alu_dataa,
  output logic [DATA_W-1:0]  alu_datab,
  output logic [3:0]         alu_function,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_illegal,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;

  state_t              state_r;
  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   opb_r;
  logic [3:0]          func_r;
  logic [SHAMT_W-1:0]  cnt_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_illegal_r;
  logic                req_ready_r;
  logic                rsp_valid_r;
  logic                busy_r;
  logic [4:0]          dec_s;

  // Returns {legal, alu function code}; bit 3 of the code marks a shift op.
  function automatic logic [4:0] op_decode(input logic [3:0] op);
    case (op)
      4'd0:    op_decode = 5'b1_0000;
      4'd1:    op_decode = 5'b1_0010;
      4'd2:    op_decode = 5'b1_0100;
      4'd3:    op_decode = 5'b1_0101;
      4'd4:    op_decode = 5'b1_0110;
      4'd5:    op_decode = 5'b1_0111;
      4'd6:    op_decode = 5'b1_1000;
      4'd7:    op_decode = 5'b1_1001;
      4'd8:    op_decode = 5'b1_1010;
      default: op_decode = 5'b0_0000;
    endcase
  endfunction

  assign dec_s        = op_decode(req_op);
  assign alu_dataa    = acc_r;
  assign alu_datab    = opb_r;
  assign alu_function = func_r;
  assign req_ready    = req_ready_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_illegal  = rsp_illegal_r;
  assign busy         = busy_r;

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      acc_r         <= {DATA_W{1'b0}};
      opb_r         <= {DATA_W{1'b0}};
      func_r        <= 4'b0000;
      cnt_r         <= {SHAMT_W{1'b0}};
      rsp_data_r    <= {DATA_W{1'b0}};
      rsp_illegal_r <= 1'b0;
      req_ready_r   <= 1'b1;
      rsp_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (!dec_s[4]) begin
              rsp_data_r    <= {DATA_W{1'b0}};
              rsp_illegal_r <= 1'b1;
              rsp_valid_r   <= 1'b1;
              state_r       <= RESP;
            end else if (dec_s[3] && (req_shamt == {SHAMT_W{1'b0}})) begin
              func_r        <= dec_s[3:0];
              rsp_data_r    <= req_a;
              rsp_illegal_r <= 1'b0;
              rsp_valid_r   <= 1'b1;
              state_r       <= RESP;
            end else if (dec_s[3]) begin
              func_r        <= dec_s[3:0];
              acc_r         <= req_a;
              cnt_r         <= req_shamt;
              rsp_illegal_r <= 1'b0;
              state_r       <= SHIFT;
            end else begin
              func_r        <= dec_s[3:0];
              acc_r         <= req_a;
              opb_r         <= req_b;
              rsp_illegal_r <= 1'b0;
              state_r       <= EXEC;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        EXEC: begin
          rsp_data_r  <= alu_result;
          rsp_valid_r <= 1'b1;
          state_r     <= RESP;
        end
        SHIFT: begin
          acc_r <= alu_result;
          cnt_r <= cnt_r - {{(SHAMT_W-1){1'b0}}, 1'b1};
          if (cnt_r == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
            rsp_data_r  <= alu_result;
            rsp_valid_r <= 1'b1;
            state_r     <= RESP;
          end else begin
            state_r <= SHIFT;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          req_ready_r <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural single-bit-shift ALU
// attached; expected results and latencies are hand-computed constants.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_shamt;
  logic [31:0] alu_dataa;
  logic [31:0] alu_datab;
  logic [3:0]  alu_function;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_illegal;
  logic        busy;

  int total = 0;
  int bad   = 0;

  alu_op_sequencer #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
    .alu_dataa(alu_dataa), .alu_datab(alu_datab), .alu_function(alu_function),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_illegal(rsp_illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference ALU: one-bit shifts, wrapping arithmetic.
  always_comb begin
    case (alu_function)
      4'b0000: alu_result = alu_dataa + alu_datab;
      4'b0010: alu_result = alu_dataa - alu_datab;
      4'b0100: alu_result = alu_dataa & alu_datab;
      4'b0101: alu_result = alu_dataa | alu_datab;
      4'b0110: alu_result = ~(alu_dataa | alu_datab);
      4'b0111: alu_result = alu_dataa ^ alu_datab;
      4'b1000: alu_result = {alu_dataa[30:0], 1'b0};
      4'b1001: alu_result = {alu_dataa[31], alu_dataa[31:1]};
      4'b1010: alu_result = {1'b0, alu_dataa[31:1]};
      default: alu_result = 32'h0000_0000;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request, measure accept-to-valid latency, check result, retire it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] exp_data, input logic exp_ill,
                        input int exp_lat, input logic [3:0] exp_func);
    int lat;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_shamt = sh;
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    if (!rsp_valid) chk({tag, "_func"}, {28'd0, alu_function}, {28'd0, exp_func});
    while (!rsp_valid && lat < 100) begin
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_data"}, rsp_data, exp_data);
    chk({tag, "_ill"}, {31'd0, rsp_illegal}, {31'd0, exp_ill});
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_done"}, {30'd0, req_ready, rsp_valid}, 32'd2);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0;
    req_shamt = 5'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", {28'd0, req_ready, rsp_valid, busy, rsp_illegal}, 32'h8);
    chk("rst_a", alu_dataa, 32'd0);
    chk("rst_b", alu_datab, 32'd0);
    chk("rst_f", {28'd0, alu_function}, 32'd0);
    chk("rst_d", rsp_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("add",  4'd0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 2, 4'b0000);
    run_op("sub",  4'd1, 32'd3, 32'd5, 5'd0, 32'hFFFF_FFFE, 1'b0, 2, 4'b0010);
    run_op("and",  4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 32'h00F0_1234, 1'b0, 2, 4'b0100);
    run_op("or",   4'd3, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'hF000_0F01, 1'b0, 2, 4'b0101);
    run_op("nor",  4'd4, 32'hF000_0001, 32'h0000_0F00, 5'd0, 32'h0FFF_F0FE, 1'b0, 2, 4'b0110);
    run_op("xor",  4'd5, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd0, 32'hF00F_F00F, 1'b0, 2, 4'b0111);
    run_op("sra4", 4'd7, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b0, 5, 4'b1001);
    run_op("srl4", 4'd8, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 1'b0, 5, 4'b1010);
    run_op("sll31", 4'd6, 32'd1, 32'd0, 5'd31, 32'h8000_0000, 1'b0, 32, 4'b1000);
    run_op("sll0", 4'd6, 32'h0000_1234, 32'd0, 5'd0, 32'h0000_1234, 1'b0, 1, 4'b1000);
    run_op("ill",  4'hF, 32'h1111_1111, 32'h2222_2222, 5'd3, 32'd0, 1'b1, 1, 4'b0000);

    // Backpressure: response held 3 cycles while a second request waits.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd0; req_a = 32'd40; req_b = 32'd2; req_shamt = 5'd0;
    @(posedge clk); #1;
    req_a = 32'd10; req_b = 32'd20;
    @(posedge clk); #1;
    chk("bp_valid0", {31'd0, rsp_valid}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {30'd0, rsp_valid, req_ready}, 32'd2);
      chk("bp_data", rsp_data, 32'd42);
    end
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("bp_idle", {30'd0, req_ready, rsp_valid}, 32'd2);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_acc", {30'd0, req_ready, busy}, 32'd1);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("bp2_lat", lat, 2);
    chk("bp2_data", rsp_data, 32'd30);
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1; rsp_ready = 1'b0;

    // Reset in the middle of a 20-step shift discards the request.
    @(negedge clk);
    req_valid = 1'b1; req_op = 4'd6; req_a = 32'd1; req_shamt = 5'd20;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst", {29'd0, req_ready, rsp_valid, busy}, 32'h4);
    chk("mid_rst_a", alu_dataa, 32'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    chk("mid_rst_norsp", seen, 0);
    run_op("add11", 4'd0, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, 2, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Front-end controller that drives the combinational ALU's dataa/datab/Function inputs and captures its result. It accepts one operation request at a time over a valid/ready handshake and translates the request opcode into the ALU 4-bit Function code. Because the ALU shifts by exactly one bit, the block performs multi-bit shifts by iterating the ALU shift op shamt times. It returns the result over a valid/ready response handshake and sits between the execute-stage issue logic and the ALU.

Parameters:
DATA_W, 32, operand/result width; fixed at 32 to match the ALU.
SHAMT_W, 5, shift-amount width; shifts of 0..31.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 XOR, 6 SLL, 7 SRA, 8 SRL; 9-15 illegal
req_a  in  DATA_W  operand A (value shifted for shift ops)
req_b  in  DATA_W  operand B (ignored for shifts)
req_shamt  in  SHAMT_W  shift amount (ignored for non-shifts)
alu_dataa  out  DATA_W  to ALU dataa = internal accumulator register
alu_datab  out  DATA_W  to ALU datab = latched operand B
alu_function  out  4  to ALU Function = latched function code
alu_result  in  DATA_W  from ALU result
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_data  out  DATA_W  result
rsp_illegal  out  1  request opcode was illegal; qualified by rsp_valid
busy  out  1  high in any state except IDLE

Behaviour:
- Function map: ADD→0000, SUB→0010, AND→0100, OR→0101, NOR→0110, XOR→0111, SLL→1000, SRA→1001, SRL→1010.
- Reset, synchronous and active-high, sets: state=IDLE, accumulator=0, operand B=0, function=0000, counter=0, rsp_data=0, rsp_illegal=0. Outputs after reset: req_ready=1, rsp_valid=0, busy=0, alu_* all zero.
- rst wins over every other event, including mid-shift and a pending response. Any in-flight request is discarded with no response.
- States: IDLE, EXEC, SHIFT, RESP.
- IDLE: req_ready=1. On req_valid, latch the request at the edge:
  - Illegal opcode: go to RESP with rsp_data=0 and rsp_illegal=1.
  - Shift op with shamt=0: go to RESP with rsp_data=req_a and rsp_illegal=0.
  - Shift op with shamt>0: set accumulator=req_a, counter=shamt, and go to SHIFT.
  - Otherwise: set accumulator=req_a, B=req_b, and go to EXEC.
- EXEC: the ALU is driven for one cycle. At the edge, rsp_data=alu_result and the state goes to RESP.
- SHIFT: at each edge, accumulator=alu_result and counter decrements. When the counter is 1 at the edge, rsp_data=alu_result and the state goes to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_illegal stay stable until a cycle with rsp_ready=1; that edge returns the state to IDLE.
- No request is accepted in the same cycle a response completes. Throughput is at most one request per latency+1 cycles.
- Latency from the accept edge to rsp_valid high:
  - Non-shift: 2 cycles.
  - Shift by N>0: N+1 cycles.
  - Illegal op or shamt=0: 1 cycle.
- req_* inputs are ignored outside IDLE. Requests are never dropped while req_ready=0; the requester must hold them.
- Arithmetic wraps modulo 2^32. Overflow and carry are not reported.
- alu_function keeps its last latched value in IDLE/RESP; the ALU output is don't-care there.

Test Plan:
- ADD a=5, b=7 → rsp_valid 2 cycles after accept, rsp_data=12, rsp_illegal=0; alu_function=0000 during EXEC.
- SUB a=3, b=5 → rsp_data=0xFFFFFFFE. XOR a=0xFF00FF00, b=0x0F0F0F0F → rsp_data=0xF00FF00F.
- SRA a=0x80000000, shamt=4 → alu_function=1001 for 4 cycles, rsp_valid at cycle 5, rsp_data=0xF8000000. SRL on the same values → 0x08000000. SLL a=1, shamt=31 → 0x80000000 at cycle 32.
- SLL shamt=0, a=0x1234 → rsp_data=0x1234 after 1 cycle. req_op=4'hF → rsp_illegal=1, rsp_data=0.
- Backpressure: hold rsp_ready=0 for 3 cycles after ADD completes → rsp_valid and rsp_data stable, req_ready=0 throughout. A second req_valid held during that time is accepted only in the cycle after the rsp_ready handshake.
- Reset mid-shift (shamt=20, rst at cycle 6) → next cycle state is IDLE, req_ready=1, rsp_valid=0, no response emitted. A following ADD 1+1 returns 2.
